// File: rtl/pcm_stream_ctrl_if.sv
// FIFO write port and VRAM read port seen by the PCM stream controller.
// The master side is the controller and the slave side is the FIFO/VRAM arbiter.
interface pcm_stream_ctrl_if #(
  parameter int unsigned ADDR_W = 17
);
  logic [7:0]        fifo_wrdata;
  logic              fifo_write;
  logic              fifo_full;
  logic              fifo_almost_empty;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_req;
  logic              vram_ack;
  logic [7:0]        vram_rddata;

  modport master (
    output fifo_wrdata,
    output fifo_write,
    output vram_addr,
    output vram_req,
    input  fifo_full,
    input  fifo_almost_empty,
    input  vram_ack,
    input  vram_rddata
  );

  modport slave (
    input  fifo_wrdata,
    input  fifo_write,
    input  vram_addr,
    input  vram_req,
    output fifo_full,
    output fifo_almost_empty,
    output vram_ack,
    output vram_rddata
  );
endinterface

// File: rtl/pcm_stream_ctrl.sv
// PCM FIFO write-side controller: arbitrates host byte writes against a VRAM
// streaming engine that refills the FIFO in bursts whenever it runs almost empty.
// Handles address wrap, looping, end-of-stream and the sticky host overflow flag.
module pcm_stream_ctrl #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned BURST  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cpu_wrdata_i,
  input  logic              cpu_write_i,
  input  logic              stream_enable_i,
  input  logic              stream_loop_i,
  input  logic [ADDR_W-1:0] stream_start_i,
  input  logic [ADDR_W-1:0] stream_length_i,
  input  logic              ovf_clear_i,
  input  logic              fifo_reset_i,
  pcm_stream_ctrl_if.master bus,
  output logic              stream_busy_o,
  output logic              stream_done_o,
  output logic              cpu_overflow_o
);

  localparam int unsigned   BW       = $clog2(BURST + 1);
  localparam logic [BW-1:0] BurstMax = BW'(BURST);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDone} state_e;

  state_e            state_q, state_d;
  logic              en_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  // One extra bit so a length of 0 can stand for a full 2^ADDR_W bytes.
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [7:0]        hold_q, hold_d;
  // A flush arrived while a VRAM read was outstanding; its data must be dropped.
  logic              drop_q, drop_d;
  logic              fifo_write_q, fifo_write_d;
  logic [7:0]        fifo_wrdata_q, fifo_wrdata_d;
  logic              vram_req_q;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic              busy_q, done_q;
  logic              ovf_q, ovf_d;

  logic              en_rise;
  logic              host_ok;
  logic              dma_push;
  logic              trigger;
  logic [ADDR_W:0]   len_full;
  logic [BW-1:0]     burst_inc;

  assign en_rise   = stream_enable_i & ~en_q;
  assign len_full  = {(stream_length_i == '0), stream_length_i};
  assign burst_inc = burst_q + BW'(1);

  // Host always owns the FIFO port; nothing is forwarded in a flush cycle.
  assign host_ok  = cpu_write_i & ~bus.fifo_full & ~fifo_reset_i;
  assign dma_push = (state_q == StHold) & ~cpu_write_i & ~bus.fifo_full & ~fifo_reset_i;
  assign trigger  = stream_enable_i & bus.fifo_almost_empty & ~bus.fifo_full & (rem_q != '0);

  // Streaming engine next-state, pointer, remaining count and burst tracking.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    hold_d  = hold_q;
    drop_d  = drop_q;

    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (trigger) begin
          state_d = StReq;
          burst_d = '0;
        end
      end

      StReq: begin
        if (fifo_reset_i) begin
          drop_d = 1'b1;
        end
        // The handshake always completes, even when disabled or flushed.
        if (bus.vram_ack) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - (ADDR_W + 1)'(1);
          if (drop_q || fifo_reset_i) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            hold_d  = bus.vram_rddata;
            state_d = StHold;
          end
        end
      end

      StHold: begin
        if (fifo_reset_i) begin
          state_d = StIdle;
        end else if (dma_push) begin
          burst_d = burst_inc;
          if ((rem_q == '0) && !stream_loop_i) begin
            state_d = StDone;
          end else begin
            if (rem_q == '0) begin
              ptr_d = stream_start_i;
              rem_d = len_full;
            end
            if ((burst_inc == BurstMax) || !stream_enable_i) begin
              state_d = StIdle;
            end else begin
              state_d = StReq;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A fresh enable edge re-arms the stream regardless of engine state.
    if (en_rise) begin
      ptr_d   = stream_start_i;
      rem_d   = len_full;
      burst_d = '0;
    end
  end

  // FIFO write port, VRAM address capture and overflow flag next values.
  always_comb begin
    fifo_write_d  = host_ok | dma_push;
    fifo_wrdata_d = fifo_wrdata_q;
    if (host_ok) begin
      fifo_wrdata_d = cpu_wrdata_i;
    end else if (dma_push) begin
      fifo_wrdata_d = hold_q;
    end

    // Address is captured only on entry to REQ so it stays stable while requested.
    vram_addr_d = vram_addr_q;
    if ((state_d == StReq) && (state_q != StReq)) begin
      vram_addr_d = ptr_d;
    end

    // Setting wins over a simultaneous clear.
    ovf_d = (ovf_q & ~ovf_clear_i) | (cpu_write_i & bus.fifo_full & ~fifo_reset_i);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      en_q          <= 1'b0;
      ptr_q         <= '0;
      rem_q         <= '0;
      burst_q       <= '0;
      hold_q        <= '0;
      drop_q        <= 1'b0;
      fifo_write_q  <= 1'b0;
      fifo_wrdata_q <= '0;
      vram_req_q    <= 1'b0;
      vram_addr_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= stream_enable_i;
      ptr_q         <= ptr_d;
      rem_q         <= rem_d;
      burst_q       <= burst_d;
      hold_q        <= hold_d;
      drop_q        <= drop_d;
      fifo_write_q  <= fifo_write_d;
      fifo_wrdata_q <= fifo_wrdata_d;
      vram_req_q    <= (state_d == StReq);
      vram_addr_q   <= vram_addr_d;
      busy_q        <= (state_d != StIdle);
      done_q        <= (state_d == StDone);
      ovf_q         <= ovf_d;
    end
  end

  assign bus.fifo_write  = fifo_write_q;
  assign bus.fifo_wrdata = fifo_wrdata_q;
  assign bus.vram_req    = vram_req_q;
  assign bus.vram_addr   = vram_addr_q;
  assign stream_busy_o   = busy_q;
  assign stream_done_o   = done_q;
  assign cpu_overflow_o  = ovf_q;

endmodule

// File: doc/pcm_stream_ctrl.md
# pcm_stream_ctrl

Write-side controller for the PCM audio FIFO. It arbitrates FIFO writes between host register writes and a VRAM streaming engine. When the FIFO drains to almost-empty, the engine fetches sample bytes from VRAM in bursts and pushes them into the FIFO. It also handles address wrap, looping, end-of-stream and overflow flags, and sits between the register file / VRAM arbiter and the PCM playback block.

## Interface
Parameters:
- ADDR_W, 17, VRAM byte address width
- BURST, 16, max bytes fetched per almost-empty trigger (power of two, 2..64)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_wrdata  in  8  host byte for FIFO
- cpu_write  in  1  one-cycle host write strobe
- stream_enable  in  1  level; enables VRAM streaming
- stream_loop  in  1  level; wrap to start at end instead of stopping
- stream_start  in  ADDR_W  first byte address
- stream_length  in  ADDR_W  byte count; 0 means 2^ADDR_W
- ovf_clear  in  1  one-cycle clear of cpu_overflow
- fifo_reset  in  1  FIFO flush strobe (also consumed by FIFO)
- fifo_full  in  1  from FIFO
- fifo_almost_empty  in  1  from FIFO
- fifo_wrdata  out  8  byte to FIFO
- fifo_write  out  1  FIFO write strobe
- vram_addr  out  ADDR_W  read address
- vram_req  out  1  read request, held until ack
- vram_ack  in  1  one-cycle; vram_rddata valid same cycle
- vram_rddata  in  8  read data
- stream_busy  out  1  engine not IDLE
- stream_done  out  1  one-cycle pulse at non-loop end of stream
- cpu_overflow  out  1  sticky: host write dropped while full

## Operation
- States: IDLE, REQ, HOLD, DONE.
- Rising edge of stream_enable (registered compare) loads ptr=stream_start and remaining=stream_length. The burst counter is cleared.
- IDLE -> REQ when stream_enable && fifo_almost_empty && !fifo_full && remaining!=0.
- REQ: vram_req=1 and vram_addr=ptr. The request stays asserted until vram_ack. On ack:
  - latch vram_rddata into hold_r;
  - advance ptr (mod 2^ADDR_W);
  - decrement remaining;
  - go to HOLD.
- HOLD: push hold_r when !fifo_full && !cpu_write, then increment the burst counter. Next state after the push:
  - if remaining==0 and stream_loop: reload ptr/remaining and continue burst rules;
  - if remaining==0 and !stream_loop: DONE;
  - if burst count==BURST, fifo_full next, or !stream_enable: IDLE;
  - else REQ.
- DONE: pulse stream_done for one cycle, then IDLE. Re-arming requires a new enable edge.
- Arbitration: a host write always wins the FIFO port. In that cycle the DMA byte stays in hold_r and retries the next cycle.
- A host write while fifo_full is dropped and sets cpu_overflow. An ovf_clear in the same cycle as an overflow leaves the flag set.
- Deasserting stream_enable mid-REQ still completes the handshake. The byte is pushed, then the engine goes to IDLE.
- fifo_reset:
  - the hold_r byte is discarded; a HOLD state goes to IDLE;
  - in REQ, the request stays up until ack, then the data is discarded and the engine goes to IDLE;
  - ptr and remaining are preserved.
- A host write in the fifo_reset cycle is not forwarded.

## Timing
- Reset values:
  - fifo_write=0, fifo_wrdata=0;
  - vram_req=0, vram_addr=0;
  - stream_busy=0, stream_done=0, cpu_overflow=0;
  - state IDLE, ptr/remaining/burst=0.
- Host path: cpu_write in cycle N gives fifo_write and fifo_wrdata registered in N+1.
- DMA path: IDLE->REQ takes one cycle after the trigger. vram_req rises the next cycle. The ack cycle latches the byte. fifo_write for that byte occurs the cycle after entering HOLD, at the earliest.
- Without host contention, vram_req reasserts one cycle after each push.
- All outputs are registered. vram_addr is stable while vram_req is high.
- fifo_write is never asserted while fifo_full is high in the same cycle.
- Back-to-back cpu_write strobes each reach the FIFO with one-cycle latency.

## Test plan
- Host only: write 0x11,0x22,0x33 on consecutive cycles into an empty FIFO -> fifo_write on 3 consecutive cycles with the same bytes, cpu_overflow=0.
- Overflow: hold fifo_full=1 and write 0xAA -> no fifo_write, cpu_overflow=1. Pulse ovf_clear -> 0.
- Burst: BURST=16, start=0x1FFF8, length=32, almost_empty held -> 16 reads, addresses 0x1FFF8..0x1FFFF then 0x00000..0x00007. The engine then goes to IDLE and re-triggers.
- End of stream: length=5, loop=0 -> exactly 5 pushes, one stream_done pulse, stream_busy falls, no further vram_req.
- Loop: length=4, loop=1, start=0x100 -> the address sequence 0x100..0x103,0x100.. repeats without stream_done.
- Contention/reset: cpu_write in the same cycle as a DMA push -> the host byte is written first and the DMA byte follows. A fifo_reset during an outstanding vram_req -> the ack data is not written, and the engine returns to IDLE.
